l1ca_acq_sequencer: RTL and testbench
=====================================

Name: l1ca_acq_sequencer

Overview:
Downstream controller for the L1 C/A code/Doppler search engine. It sweeps a PRN range through the search engine one SV at a time and compares each returned peak power against a programmable threshold. Detections are posted as result records on a valid/ready interface for the tracking-channel allocator. It sits between the search engine and the channel allocator and supplies the engine's start and sv inputs.

Parameters:
SV_FIRST, 1, first PRN of the sweep (1..32)
SV_LAST, 32, last PRN of the sweep (SV_FIRST..32)
CONFIRM_N, 2, number of consecutive above-threshold searches that declare a detection (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
sweep_start  in  1  one-cycle pulse; begins a sweep when idle
sweep_abort  in  1  one-cycle pulse; ends the sweep after the in-flight search
continuous  in  1  restart the sweep automatically at SV_LAST wrap
threshold  in  32  power threshold (word_t, unsigned)
sv_mask  in  32  bit k set = skip PRN k+1 (already tracked)
srch_start  out  1  start pulse to the search engine
srch_sv  out  6  PRN to search (sv_t); held stable while the engine is busy
srch_busy  in  1  search engine busy
srch_power  in  32  engine maximum correlation (acc_out)
srch_code  in  11  engine half-chip index of the maximum
srch_dop  in  5  engine Doppler bin of the maximum
res_valid  out  1  result record valid
res_ready  in  1  consumer accepts the record
res_sv  out  6  detected PRN
res_code  out  11  half-chip code index
res_dop  out  5  Doppler bin
res_power  out  32  peak power
sweep_busy  out  1  high from sweep acceptance until return to IDLE
sweep_done  out  1  one-cycle pulse when a sweep completes or is aborted
hit_count  out  6  detections in the current sweep; saturates at 32

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0, except srch_sv, which resets to SV_FIRST. cur_sv resets to SV_FIRST. The confirm counter and abort flag clear.
- States:
  - IDLE -> PICK on sweep_start. cur_sv loads SV_FIRST, hit_count clears, sweep_busy rises the next cycle.
  - PICK (1 cycle): uses sv_mask as sampled this cycle.
    - If the first unmasked PRN >= cur_sv and <= SV_LAST exists: cur_sv takes that PRN, next state LAUNCH.
    - Otherwise: END.
  - LAUNCH: srch_start=1 for exactly 1 cycle with srch_sv=cur_sv, then WAIT_BUSY.
  - WAIT_BUSY: wait for srch_busy=1, then WAIT_DONE. The engine raises busy on the cycle after start.
  - WAIT_DONE: on srch_busy falling (1->0), go to EVAL. The engine outputs are stable from this point until the next srch_start.
  - EVAL (1 cycle): hit = srch_power > threshold, unsigned and strict; equality is a miss.
    - Hit: capture srch_* into the res_* registers, then EMIT.
    - Miss: ADVANCE.
  - EMIT: res_valid=1. res_* stay constant until the cycle where res_valid & res_ready. On that cycle hit_count increments and the next state is ADVANCE. The block never drops a record under back-pressure.
  - ADVANCE:
    - If the abort flag is set, or cur_sv==SV_LAST: END.
    - Otherwise cur_sv+1, then PICK.
  - END: sweep_done=1 for 1 cycle.
    - If continuous=1 and no abort: cur_sv=SV_FIRST, hit_count clears, next PICK, sweep_busy stays high.
    - Otherwise: IDLE.
- sweep_abort:
  - Latched into the abort flag in any non-IDLE state.
  - The search engine cannot be cancelled, so an in-flight search completes and its result is still evaluated and emitted.
  - Ignored in IDLE.
- sweep_start while not IDLE is ignored. Simultaneous sweep_start and sweep_abort in IDLE: start wins, abort is ignored.
- All-masked range: sweep_done fires 3 cycles after sweep_start (IDLE->PICK->END) and srch_start is never asserted.
- Changing sv_mask mid-sweep affects only subsequent PICKs.
- hit_count saturates at 32 and never wraps.

Optional Feature:
ACQ_CONFIRM_EN.
- Defined: EVAL on a hit with confirm count+1 < CONFIRM_N increments the count and goes to LAUNCH, re-searching the same PRN.
  - A record is emitted only after CONFIRM_N consecutive hits. Reported values come from the last search.
  - A miss clears the count and goes to ADVANCE.
  - Abort during confirmation also clears the count and goes to ADVANCE.
- Undefined: a single hit emits immediately, and the confirm counter logic is absent.

Decomposition:
- Shared package (common_gnss_types_pkg):
  - acq_seq_state_t enum: IDLE, PICK, LAUNCH, WAIT_BUSY, WAIT_DONE, EVAL, EMIT, ADVANCE, END.
  - acq_result_t packed struct {sv, code, dop, power}.
  - N_SV=32.
- Sub-module l1ca_sv_picker: combinational priority encoder. Inputs are mask, cur_sv and SV_LAST. Outputs are found and next_sv.

Test Plan:
- Mask=0, SV range 1..3, threshold=1000; engine BFM returns powers 500, 1500, 1000 -> exactly one record {sv=2}; hit_count=1; sweep_done once; srch_start pulsed 3 times.
- sv_mask=32'hFFFF_FFFF, sweep_start -> no srch_start; sweep_done exactly 3 cycles after start; hit_count=0.
- Hit on SV 5 with res_ready held low for 50 cycles -> res_valid high and res_* constant for 50 cycles; no srch_start until the handshake.
- sweep_abort during the SV 7 search, engine reports power above threshold -> SV 7 record emitted, then sweep_done; state IDLE, SV 8 never launched.
- continuous=1, range 31..32 -> second srch_start for SV 31 follows sweep_done; hit_count cleared at wrap; rst asserted mid-WAIT_DONE -> all outputs 0 immediately, srch_sv=SV_FIRST.
- ACQ_CONFIRM_EN, CONFIRM_N=2: SV 4 powers hit, miss -> no record; SV 6 hit, hit -> one record after the second search.

Source files
------------

// File: rtl/common_gnss_types_pkg.sv
// -----------------------------------------------------------------------------
// common_gnss_types_pkg
// Shared types for the L1 C/A acquisition path.
//   N_SV            : number of GPS PRNs handled by the search path (32)
//   sv_t            : PRN number, 1..32 (6 bits)
//   word_t          : 32-bit unsigned power / threshold word
//   code_t          : half-chip code index of a correlation peak
//   dop_t           : Doppler bin index of a correlation peak
//   acq_seq_state_t : acquisition sequencer FSM states
//   acq_result_t    : detection record {sv, code, dop, power}
// -----------------------------------------------------------------------------
package common_gnss_types_pkg;

    localparam int N_SV = 32;

    typedef logic [5:0]  sv_t;
    typedef logic [31:0] word_t;
    typedef logic [10:0] code_t;
    typedef logic [4:0]  dop_t;

    typedef enum logic [3:0] {
        IDLE,
        PICK,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        EVAL,
        EMIT,
        ADVANCE,
        END
    } acq_seq_state_t;

    typedef struct packed {
        sv_t   sv;
        code_t code;
        dop_t  dop;
        word_t power;
    } acq_result_t;

endpackage

// File: rtl/l1ca_sv_picker.sv
// -----------------------------------------------------------------------------
// l1ca_sv_picker
// Combinational priority encoder that finds the lowest PRN p with
// cur_sv <= p <= sv_last whose skip bit mask[p-1] is clear.
//   mask    in  32  bit k set = skip PRN k+1
//   cur_sv  in  6   lowest PRN that may be chosen
//   sv_last in  6   highest PRN that may be chosen
//   found   out 1   an eligible PRN exists
//   next_sv out 6   the eligible PRN (cur_sv when nothing is found)
// -----------------------------------------------------------------------------
module l1ca_sv_picker
    import common_gnss_types_pkg::*;
(
    input  logic [N_SV-1:0] mask,
    input  sv_t             cur_sv,
    input  sv_t             sv_last,
    output logic            found,
    output sv_t             next_sv
);

    // Scan from the top down so the lowest eligible PRN is the last one written.
    always_comb begin
        found   = 1'b0;
        next_sv = cur_sv;
        for (int p = N_SV; p >= 1; p--) begin
            if ((sv_t'(p) >= cur_sv) && (sv_t'(p) <= sv_last) && !mask[p-1]) begin
                found   = 1'b1;
                next_sv = sv_t'(p);
            end
        end
    end

endmodule

// File: rtl/l1ca_acq_sequencer.sv
// -----------------------------------------------------------------------------
// l1ca_acq_sequencer
// Sweeps PRNs SV_FIRST..SV_LAST through the C/A code/Doppler search engine one
// at a time, compares each returned peak power against a threshold and posts
// detections as result records on a valid/ready interface.
//
// Optional feature macro: ACQ_CONFIRM_EN
//   When defined, a PRN must exceed the threshold on CONFIRM_N consecutive
//   searches before a record is posted; the reported values come from the
//   last search. When undefined, a single hit posts a record.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   sweep_start           pulse: begin a sweep when idle
//   sweep_abort           pulse: end the sweep after the in-flight search
//   continuous            restart from SV_FIRST when the sweep completes
//   threshold             unsigned power threshold (hit = power > threshold)
//   sv_mask               bit k set = skip PRN k+1
//   srch_start/srch_sv    search engine launch pulse and PRN
//   srch_busy             search engine busy
//   srch_power/code/dop   search engine peak power, code index, Doppler bin
//   res_valid/res_ready   result record handshake
//   res_sv/code/dop/power result record
//   sweep_busy            high from sweep acceptance until back in IDLE
//   sweep_done            one-cycle pulse when a sweep completes or aborts
//   hit_count             detections in the current sweep, saturating at 32
// -----------------------------------------------------------------------------
module l1ca_acq_sequencer
    import common_gnss_types_pkg::*;
#(
    parameter int SV_FIRST  = 1,
    parameter int SV_LAST   = 32,
    parameter int CONFIRM_N = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sweep_start,
    input  logic        sweep_abort,
    input  logic        continuous,
    input  logic [31:0] threshold,
    input  logic [31:0] sv_mask,
    output logic        srch_start,
    output logic [5:0]  srch_sv,
    input  logic        srch_busy,
    input  logic [31:0] srch_power,
    input  logic [10:0] srch_code,
    input  logic [4:0]  srch_dop,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [5:0]  res_sv,
    output logic [10:0] res_code,
    output logic [4:0]  res_dop,
    output logic [31:0] res_power,
    output logic        sweep_busy,
    output logic        sweep_done,
    output logic [5:0]  hit_count
);

    localparam sv_t SV_FIRST_SV = sv_t'(SV_FIRST);
    localparam sv_t SV_LAST_SV  = sv_t'(SV_LAST);
    localparam sv_t HIT_MAX     = sv_t'(N_SV);

    // An illegal configuration never accepts a sweep rather than sweeping
    // outside the PRN range.
    localparam bit PARAMS_OK = (SV_FIRST >= 1) && (SV_LAST <= N_SV) &&
                               (SV_LAST >= SV_FIRST) && (CONFIRM_N >= 1);

    acq_seq_state_t state_q, state_d;
    sv_t            cur_sv_q, cur_sv_d;
    logic           abort_q, abort_d;
    logic [5:0]     hit_count_q, hit_count_d;
    acq_result_t    res_q, res_d;
    logic           res_valid_q, res_valid_d;
    logic           srch_start_q, srch_start_d;
    sv_t            srch_sv_q, srch_sv_d;
    logic           sweep_busy_q, sweep_busy_d;
    logic           sweep_done_q, sweep_done_d;

`ifdef ACQ_CONFIRM_EN
    localparam int CONF_W = (CONFIRM_N < 2) ? 1 : $clog2(CONFIRM_N + 1);
    logic [CONF_W-1:0] conf_q, conf_d;
`endif

    logic pick_found;
    sv_t  pick_sv;
    logic hit;
    logic abort_now;

    l1ca_sv_picker u_picker (
        .mask    (sv_mask),
        .cur_sv  (cur_sv_q),
        .sv_last (SV_LAST_SV),
        .found   (pick_found),
        .next_sv (pick_sv)
    );

    assign hit       = srch_power > threshold;
    // An abort arriving in the deciding cycle counts as already latched.
    assign abort_now = abort_q | sweep_abort;

    always_comb begin
        state_d      = state_q;
        cur_sv_d     = cur_sv_q;
        abort_d      = abort_q;
        hit_count_d  = hit_count_q;
        res_d        = res_q;
        res_valid_d  = res_valid_q;
        srch_start_d = 1'b0;
        srch_sv_d    = srch_sv_q;
        sweep_busy_d = sweep_busy_q;
        sweep_done_d = 1'b0;
`ifdef ACQ_CONFIRM_EN
        conf_d       = conf_q;
`endif

        if ((state_q != IDLE) && sweep_abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sweep_start && PARAMS_OK) begin
                    state_d      = PICK;
                    cur_sv_d     = SV_FIRST_SV;
                    hit_count_d  = '0;
                    abort_d      = 1'b0;
                    sweep_busy_d = 1'b1;
                end
            end
            PICK: begin
                if (pick_found) begin
                    cur_sv_d     = pick_sv;
                    srch_start_d = 1'b1;
                    srch_sv_d    = pick_sv;
                    state_d      = LAUNCH;
                end else begin
                    state_d = END;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (srch_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!srch_busy) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
`ifdef ACQ_CONFIRM_EN
                if (hit) begin
                    if ((int'(conf_q) + 1) < CONFIRM_N) begin
                        if (abort_now) begin
                            conf_d  = '0;
                            state_d = ADVANCE;
                        end else begin
                            conf_d       = conf_q + 1'b1;
                            srch_start_d = 1'b1;
                            srch_sv_d    = cur_sv_q;
                            state_d      = LAUNCH;
                        end
                    end else begin
                        conf_d      = '0;
                        res_d       = '{sv: cur_sv_q, code: srch_code, dop: srch_dop, power: srch_power};
                        res_valid_d = 1'b1;
                        state_d     = EMIT;
                    end
                end else begin
                    conf_d  = '0;
                    state_d = ADVANCE;
                end
`else
                if (hit) begin
                    res_d       = '{sv: cur_sv_q, code: srch_code, dop: srch_dop, power: srch_power};
                    res_valid_d = 1'b1;
                    state_d     = EMIT;
                end else begin
                    state_d = ADVANCE;
                end
`endif
            end
            EMIT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (hit_count_q != HIT_MAX) begin
                        hit_count_d = hit_count_q + 6'd1;
                    end
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (abort_now || (cur_sv_q == SV_LAST_SV)) begin
                    state_d = END;
                end else begin
                    cur_sv_d = cur_sv_q + 6'd1;
                    state_d  = PICK;
                end
            end
            END: begin
                sweep_done_d = 1'b1;
                if (continuous && !abort_now) begin
                    cur_sv_d    = SV_FIRST_SV;
                    hit_count_d = '0;
                    state_d     = PICK;
                end else begin
                    abort_d      = 1'b0;
                    sweep_busy_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_sv_q     <= SV_FIRST_SV;
            abort_q      <= 1'b0;
            hit_count_q  <= '0;
            res_q        <= '0;
            res_valid_q  <= 1'b0;
            srch_start_q <= 1'b0;
            srch_sv_q    <= SV_FIRST_SV;
            sweep_busy_q <= 1'b0;
            sweep_done_q <= 1'b0;
`ifdef ACQ_CONFIRM_EN
            conf_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cur_sv_q     <= cur_sv_d;
            abort_q      <= abort_d;
            hit_count_q  <= hit_count_d;
            res_q        <= res_d;
            res_valid_q  <= res_valid_d;
            srch_start_q <= srch_start_d;
            srch_sv_q    <= srch_sv_d;
            sweep_busy_q <= sweep_busy_d;
            sweep_done_q <= sweep_done_d;
`ifdef ACQ_CONFIRM_EN
            conf_q       <= conf_d;
`endif
        end
    end

    assign srch_start = srch_start_q;
    assign srch_sv    = srch_sv_q;
    assign res_valid  = res_valid_q;
    assign res_sv     = res_q.sv;
    assign res_code   = res_q.code;
    assign res_dop    = res_q.dop;
    assign res_power  = res_q.power;
    assign sweep_busy = sweep_busy_q;
    assign sweep_done = sweep_done_q;
    assign hit_count  = hit_count_q;

endmodule

// File: tb/tb_l1ca_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_l1ca_acq_sequencer
// Directed bench for l1ca_acq_sequencer (SV_FIRST=1, SV_LAST=32). A search
// engine model answers each srch_start with a fixed-length busy window and a
// per-PRN power; expected records go into a scoreboard queue that a monitor
// drains on every res_valid & res_ready handshake.
// -----------------------------------------------------------------------------
module tb_l1ca_acq_sequencer;
    import common_gnss_types_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sweep_start = 1'b0;
    logic        sweep_abort = 1'b0;
    logic        continuous = 1'b0;
    logic [31:0] threshold = '0;
    logic [31:0] sv_mask = '0;
    logic        srch_start;
    logic [5:0]  srch_sv;
    logic        srch_busy;
    logic [31:0] srch_power;
    logic [10:0] srch_code;
    logic [4:0]  srch_dop;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [5:0]  res_sv;
    logic [10:0] res_code;
    logic [4:0]  res_dop;
    logic [31:0] res_power;
    logic        sweep_busy;
    logic        sweep_done;
    logic [5:0]  hit_count;

    int total = 0;
    int bad   = 0;

    acq_result_t exp_q[$];
    word_t       power_ovr[$];
    word_t       power_tbl[1:32];
    int          launches = 0;
    int          last_launch = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    l1ca_acq_sequencer #(
        .SV_FIRST  (1),
        .SV_LAST   (32),
        .CONFIRM_N (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sweep_start (sweep_start),
        .sweep_abort (sweep_abort),
        .continuous  (continuous),
        .threshold   (threshold),
        .sv_mask     (sv_mask),
        .srch_start  (srch_start),
        .srch_sv     (srch_sv),
        .srch_busy   (srch_busy),
        .srch_power  (srch_power),
        .srch_code   (srch_code),
        .srch_dop    (srch_dop),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sv      (res_sv),
        .res_code    (res_code),
        .res_dop     (res_dop),
        .res_power   (res_power),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .hit_count   (hit_count)
    );

    // The engine model reports code = 7*PRN and dop = PRN[4:0] for every search.
    function automatic acq_result_t mkRec(input int sv, input word_t p);
        acq_result_t r;
        r.sv    = sv_t'(sv);
        r.code  = code_t'(sv * 7);
        r.dop   = dop_t'(sv);
        r.power = p;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] mask, input word_t thr,
                                 input logic cont, input logic rdy);
        sv_mask     = mask;
        threshold   = thr;
        continuous  = cont;
        res_ready   = rdy;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        int c0 = done_cnt;
        int n  = 0;
        while ((done_cnt == c0) && (n < budget)) begin
            step();
            n++;
        end
        checkOutput({name, " sweep_done count"}, 64'(done_cnt - c0), 64'd1);
    endtask

    // Search engine model: busy rises the cycle after srch_start, stays high
    // for four cycles, and results appear as busy falls.
    initial begin : engine
        sv_t         s;
        word_t       p;
        acq_result_t r;
        srch_busy  = 1'b0;
        srch_power = '0;
        srch_code  = '0;
        srch_dop   = '0;
        forever begin
            @(negedge clk);
            if (srch_start && !rst) begin
                s = srch_sv;
                launches++;
                last_launch = int'(s);
                @(negedge clk);
                srch_busy = 1'b1;
                repeat (4) @(negedge clk);
                p = (power_ovr.size() > 0) ? power_ovr.pop_front() : power_tbl[s];
                r = mkRec(int'(s), p);
                srch_power = r.power;
                srch_code  = r.code;
                srch_dop   = r.dop;
                srch_busy  = 1'b0;
            end
        end
    end

    // Scoreboard monitor and sweep_done counter.
    always @(negedge clk) begin
        if (!rst) begin
            if (sweep_done) begin
                done_cnt++;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected record: got sv=%0d power=%0d, want none",
                             res_sv, res_power);
                end else begin
                    checkOutput("record", 64'({res_sv, res_code, res_dop, res_power}),
                                64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int          l0;
        int          n;
        int          seen;
        logic        ok;
        acq_result_t rec;

        for (int i = 1; i <= 32; i++) begin
            power_tbl[i] = '0;
        end

        // Reset state
        repeat (3) step();
        checkOutput("reset srch_sv", 64'(srch_sv), 64'd1);
        checkOutput("reset srch_start", 64'(srch_start), 64'd0);
        checkOutput("reset res_valid", 64'(res_valid), 64'd0);
        checkOutput("reset sweep_busy", 64'(sweep_busy), 64'd0);
        checkOutput("reset hit_count", 64'(hit_count), 64'd0);
        rst = 1'b0;
        step();

        // PRNs 1..3, powers 500/1500/1000 against 1000: only PRN 2 detects
        $display("[TB] sweep 1..3");
        power_tbl[1] = 32'd500;
        power_tbl[2] = 32'd1500;
        power_tbl[3] = 32'd1000;
        exp_q.push_back(mkRec(2, 32'd1500));
        l0 = launches;
        applyStimulus(~32'h7, 32'd1000, 1'b0, 1'b1);
        checkOutput("t1 sweep_busy rises", 64'(sweep_busy), 64'd1);
        waitDone(400, "t1");
        checkOutput("t1 launches", 64'(launches - l0), 64'd3);
        checkOutput("t1 hit_count", 64'(hit_count), 64'd1);
        checkOutput("t1 sweep_busy low", 64'(sweep_busy), 64'd0);
        checkOutput("t1 scoreboard drained", 64'(exp_q.size()), 64'd0);

        // All PRNs masked: done 3 cycles after start, no launches
        $display("[TB] all masked");
        l0 = launches;
        sv_mask     = 32'hFFFF_FFFF;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        seen = 0;
        for (int k = 1; k <= 6; k++) begin
            if (sweep_done && (seen == 0)) begin
                seen = k;
            end
            step();
        end
        checkOutput("t2 done latency", 64'(seen), 64'd3);
        checkOutput("t2 launches", 64'(launches - l0), 64'd0);
        checkOutput("t2 hit_count", 64'(hit_count), 64'd0);

        // Hit on PRN 5 held under back-pressure for 50 cycles
        $display("[TB] back-pressure on PRN 5");
        power_tbl[5] = 32'd2000;
        rec = mkRec(5, 32'd2000);
        exp_q.push_back(rec);
        applyStimulus(~(32'h1 << 4), 32'd1000, 1'b0, 1'b0);
        n = 0;
        while (!res_valid && (n < 200)) begin
            step();
            n++;
        end
        checkOutput("t3 res_valid seen", 64'(res_valid), 64'd1);
        l0 = launches;
        ok = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (!res_valid || ({res_sv, res_code, res_dop, res_power} !== rec)) begin
                ok = 1'b0;
            end
        end
        checkOutput("t3 record held", 64'(ok), 64'd1);
        checkOutput("t3 no launch while held", 64'(launches - l0), 64'd0);
        res_ready = 1'b1;
        waitDone(100, "t3");
        checkOutput("t3 hit_count", 64'(hit_count), 64'd1);

        // Abort during the PRN 7 search: PRN 7 still reported, PRN 8 never run
        $display("[TB] abort during PRN 7");
        power_tbl[7] = 32'd3000;
        power_tbl[8] = 32'd3000;
        exp_q.push_back(mkRec(7, 32'd3000));
        l0 = launches;
        applyStimulus(~(32'h3 << 6), 32'd1000, 1'b0, 1'b1);
        n = 0;
        while (!srch_busy && (n < 50)) begin
            step();
            n++;
        end
        checkOutput("t4 in-flight sv", 64'(srch_sv), 64'd7);
        sweep_abort = 1'b1;
        step();
        sweep_abort = 1'b0;
        waitDone(100, "t4");
        repeat (10) step();
        checkOutput("t4 launches", 64'(launches - l0), 64'd1);
        checkOutput("t4 last launch", 64'(last_launch), 64'd7);
        checkOutput("t4 hit_count", 64'(hit_count), 64'd1);
        checkOutput("t4 sweep_busy low", 64'(sweep_busy), 64'd0);
        checkOutput("t4 scoreboard drained", 64'(exp_q.size()), 64'd0);

        // Continuous sweep over 31..32, then reset in WAIT_DONE
        $display("[TB] continuous 31..32");
        power_tbl[31] = 32'd5000;
        power_tbl[32] = 32'd10;
        exp_q.push_back(mkRec(31, 32'd5000));
        l0 = launches;
        applyStimulus(32'h3FFF_FFFF, 32'd1000, 1'b1, 1'b1);
        waitDone(200, "t5");
        checkOutput("t5 hit_count cleared at wrap", 64'(hit_count), 64'd0);
        checkOutput("t5 sweep_busy held", 64'(sweep_busy), 64'd1);
        n = 0;
        while ((launches < l0 + 3) && (n < 20)) begin
            step();
            n++;
        end
        checkOutput("t5 relaunch count", 64'(launches - l0), 64'd3);
        checkOutput("t5 relaunch sv", 64'(last_launch), 64'd31);
        n = 0;
        while (!srch_busy && (n < 20)) begin
            step();
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5 rst srch_sv", 64'(srch_sv), 64'd1);
        checkOutput("t5 rst sweep_busy", 64'(sweep_busy), 64'd0);
        checkOutput("t5 rst res_power", 64'(res_power), 64'd0);
        checkOutput("t5 rst res_sv", 64'(res_sv), 64'd0);
        checkOutput("t5 rst srch_start", 64'(srch_start), 64'd0);
        continuous = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();
        checkOutput("t5 idle after reset", 64'(sweep_busy), 64'd0);

`ifdef ACQ_CONFIRM_EN
        // Confirmation: PRN 4 hit then miss, PRN 6 hit then hit
        $display("[TB] confirm");
        power_ovr = '{32'd2000, 32'd500, 32'd2000, 32'd2500};
        exp_q.push_back(mkRec(6, 32'd2500));
        l0 = launches;
        applyStimulus(~((32'h1 << 3) | (32'h1 << 5)), 32'd1000, 1'b0, 1'b1);
        waitDone(400, "t6");
        checkOutput("t6 launches", 64'(launches - l0), 64'd4);
        checkOutput("t6 hit_count", 64'(hit_count), 64'd1);
`endif

        checkOutput("final scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
